latch_bank_reader: RTL and testbench

- Clocked read side for a bank of tri-state static latches that share one floating data bus.
- Selects one latch source, asserts its output enable and waits for the bus to settle.
- Filters jitter by requiring consecutive identical samples, then returns the captured word with a single-cycle ack.
- Sits between emulated NMOS register banks and the synchronous core logic, so that logic never samples a latch mid-transition.

---
 rtl/latch_bank_reader_if.sv | 28 ++
 rtl/latch_bank_reader.sv | 139 +++++++++++++
 tb/tb_latch_bank_reader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/latch_bank_reader_if.sv
// Read-side bus bundle for latch_bank_reader: request/address, shared latch bus,
// one-hot output-enable select and the captured-word/status returns.
interface latch_bank_reader_if #(
    parameter int WIDTH   = 8,
    parameter int SOURCES = 4
);
    localparam int AW = $clog2(SOURCES);

    logic               req;
    logic [AW-1:0]      addr;
    logic [WIDTH-1:0]   bus_in;
    logic               bus_drv;
    logic [SOURCES-1:0] sel_en;
    logic [WIDTH-1:0]   data;
    logic               ack;
    logic               err;
    logic               busy;

    modport master (
        output req, addr, bus_in, bus_drv,
        input  sel_en, data, ack, err, busy
    );

    modport slave (
        input  req, addr, bus_in, bus_drv,
        output sel_en, data, ack, err, busy
    );
endinterface

// File: rtl/latch_bank_reader.sv
// Clocked reader for a bank of tri-state latches on one shared bus: select, settle-filter, capture.
// Optional BUS_HOLD_EN: undriven bus reads back the last driven value instead of all-ones.
module latch_bank_reader #(
    parameter int WIDTH   = 8,
    parameter int SOURCES = 4,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 15
) (
    input logic              CLK,
    input logic              RES,
    latch_bank_reader_if.slave lb
);
    localparam int AW = $clog2(SOURCES);
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [3:0]         SETTLE_C = 4'(SETTLE);
    localparam logic [WW-1:0]      TMO_C    = WW'(TIMEOUT);
    localparam logic [AW:0]        SRC_C    = (AW + 1)'(SOURCES);
    localparam logic [SOURCES-1:0] ONE_C    = SOURCES'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SETTLE,
        ST_DONE
    } state_t;

    state_t           state, state_n;
    logic [AW-1:0]    addr_r;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] eff;
    logic [WIDTH-1:0] fallback;
    logic [3:0]       stable_cnt, stable_nx;
    logic [WW-1:0]    wait_cnt, wait_nx;
    logic             hit, tmo, oob;
    logic             ack_r, err_r;

`ifdef BUS_HOLD_EN
    logic [WIDTH-1:0] hold;

    always_ff @(posedge CLK) begin
        if (RES)
            hold <= '0;
        else if (state == ST_SETTLE && lb.bus_drv)
            hold <= lb.bus_in;
    end

    always_comb fallback = hold;
`else
    always_comb fallback = '1;
`endif

    always_comb begin
        eff = lb.bus_drv ? lb.bus_in : fallback;
        oob = {1'b0, lb.addr} >= SRC_C;

        if (eff != prev)
            stable_nx = 4'd1;
        else if (stable_cnt >= SETTLE_C)
            stable_nx = stable_cnt;
        else
            stable_nx = stable_cnt + 4'd1;

        wait_nx = wait_cnt + WW'(1);
        hit     = (stable_nx == SETTLE_C);
        tmo     = (wait_nx == TMO_C);
    end

    always_ff @(posedge CLK) begin
        if (RES)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (lb.req) state_n = oob ? ST_DONE : ST_SELECT;
            ST_SELECT: state_n = ST_SETTLE;
            ST_SETTLE: if (hit || tmo) state_n = ST_DONE;
            ST_DONE:   state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    // ack/err are registered on the transition so they are high exactly for the DONE cycle
    always_ff @(posedge CLK) begin
        if (RES) begin
            addr_r     <= '0;
            prev       <= '0;
            data_r     <= '0;
            stable_cnt <= '0;
            wait_cnt   <= '0;
            ack_r      <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (lb.req) begin
                        if (oob)
                            err_r <= 1'b1;
                        else
                            addr_r <= lb.addr;
                    end
                end
                ST_SELECT: begin
                    stable_cnt <= '0;
                    wait_cnt   <= '0;
                end
                ST_SETTLE: begin
                    stable_cnt <= stable_nx;
                    wait_cnt   <= wait_nx;
                    prev       <= eff;
                    if (hit) begin
                        data_r <= eff;
                        ack_r  <= 1'b1;
                    end else if (tmo) begin
                        err_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        lb.sel_en = '0;
        if (state == ST_SELECT || state == ST_SETTLE)
            lb.sel_en = ONE_C << addr_r;
        lb.data = data_r;
        lb.ack  = ack_r;
        lb.err  = err_r;
        lb.busy = (state != ST_IDLE);
    end
endmodule

// File: tb/tb_latch_bank_reader.sv
// Directed bench for latch_bank_reader with a per-cycle sample-history model of the SOURCES=4 instance.
// Expected undriven-bus capture follows BUS_HOLD_EN.
module tb_latch_bank_reader;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    latch_bank_reader_if #(.WIDTH(8), .SOURCES(4)) lb4 ();
    latch_bank_reader_if #(.WIDTH(8), .SOURCES(3)) lb3 ();

    latch_bank_reader #(.WIDTH(8), .SOURCES(4), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut4 (
        .CLK (clk),
        .RES (rst),
        .lb  (lb4.slave)
    );

    latch_bank_reader #(.WIDTH(8), .SOURCES(3), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut3 (
        .CLK (clk),
        .RES (rst),
        .lb  (lb3.slave)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: phase 0 idle, 1 select, 2 sampling, 3 done-ack, 4 done-err.
    int         ph;
    logic [1:0] m_addr;
    logic [7:0] m_data;
    logic [7:0] m_hold;
    logic [7:0] samp[$];

    initial begin
        logic [3:0] exp_sel;
        logic [7:0] fb, e;
        int         run;
        ph     = 0;
        m_addr = '0;
        m_data = '0;
        m_hold = '0;
        forever begin
            @(negedge clk);
            exp_sel = (ph == 1 || ph == 2) ? (4'b0001 << m_addr) : 4'b0000;
            check("model sel_en", lb4.sel_en, exp_sel);
            check("model data",   lb4.data,   m_data);
            check("model ack",    lb4.ack,    ph == 3);
            check("model err",    lb4.err,    ph == 4);
            check("model busy",   lb4.busy,   ph != 0);

            if (rst) begin
                ph     = 0;
                m_data = '0;
                m_hold = '0;
                samp.delete();
            end else begin
                case (ph)
                    0: if (lb4.req) begin
                        m_addr = lb4.addr;
                        ph     = 1;
                    end
                    1: begin
                        samp.delete();
                        ph = 2;
                    end
                    2: begin
`ifdef BUS_HOLD_EN
                        fb = m_hold;
`else
                        fb = 8'hFF;
`endif
                        e = lb4.bus_drv ? lb4.bus_in : fb;
                        if (lb4.bus_drv) m_hold = lb4.bus_in;
                        samp.push_back(e);
                        run = 0;
                        for (int i = samp.size() - 1; i >= 0; i--) begin
                            if (samp[i] != e) break;
                            run++;
                        end
                        if (run >= SETTLE) begin
                            m_data = e;
                            ph     = 3;
                        end else if (samp.size() == TIMEOUT) begin
                            ph = 4;
                        end
                    end
                    default: ph = 0;
                endcase
            end
        end
    end

    task automatic start4(input logic [1:0] a, input logic [7:0] v, input logic drv);
        lb4.req     = 1'b1;
        lb4.addr    = a;
        lb4.bus_in  = v;
        lb4.bus_drv = drv;
    endtask

    initial begin
        logic [7:0] undriven_exp;
        lb4.req = 1'b0; lb4.addr = '0; lb4.bus_in = '0; lb4.bus_drv = 1'b0;
        lb3.req = 1'b0; lb3.addr = '0; lb3.bus_in = '0; lb3.bus_drv = 1'b0;
        step();
        step();
        check("reset busy",   lb4.busy,   0);
        check("reset data",   lb4.data,   0);
        check("reset sel_en", lb4.sel_en, 0);
        rst = 1'b0;
        step();

        // Stable read of 0xA5 from source 2
        start4(2'd2, 8'hA5, 1'b1);
        step();
        lb4.req = 1'b0;
        check("s1 sel_en c1", lb4.sel_en, 4'b0100);
        step(); step(); step();
        check("s1 ack c4",  lb4.ack,  1);
        check("s1 data c4", lb4.data, 8'hA5);
        step();
        check("s1 busy c5", lb4.busy, 0);

        // Jitter: samples 0x11, 0x13, 0x13
        start4(2'd1, 8'h11, 1'b1);
        step(); lb4.req = 1'b0;
        step(); step(); lb4.bus_in = 8'h13;
        step();
        check("s2 ack c4", lb4.ack, 0);
        step();
        check("s2 ack c5",  lb4.ack,  1);
        check("s2 data c5", lb4.data, 8'h13);
        step();

        // Timeout: bus toggles every cycle
        start4(2'd0, 8'h00, 1'b1);
        for (int i = 1; i <= 19; i++) begin
            step();
            lb4.req    = 1'b0;
            lb4.bus_in = (i % 2 == 1) ? 8'hFF : 8'h00;
            check("s3 err",  lb4.err,  i == 17);
            check("s3 ack",  lb4.ack,  0);
            check("s3 busy", lb4.busy, i <= 17);
        end
        check("s3 data kept", lb4.data, 8'h13);

        // Undriven bus after a read of 0x5A
        start4(2'd3, 8'h5A, 1'b1);
        step(); lb4.req = 1'b0;
        step(); step(); step(); step();
        start4(2'd1, 8'h00, 1'b0);
        step(); lb4.req = 1'b0;
        step(); step(); step();
`ifdef BUS_HOLD_EN
        undriven_exp = 8'h5A;
`else
        undriven_exp = 8'hFF;
`endif
        check("s4 ack",  lb4.ack,  1);
        check("s4 data", lb4.data, undriven_exp);
        step();

        // Reset during SETTLE
        start4(2'd1, 8'h77, 1'b1);
        step(); lb4.req = 1'b0;
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        check("s5 sel_en", lb4.sel_en, 0);
        check("s5 data",   lb4.data,   0);
        check("s5 ack",    lb4.ack,    0);
        check("s5 err",    lb4.err,    0);
        check("s5 busy",   lb4.busy,   0);
        for (int i = 0; i < 5; i++) step();
        start4(2'd0, 8'h3C, 1'b1);
        step(); lb4.req = 1'b0;
        check("s5 sel_en fresh", lb4.sel_en, 4'b0001);
        step(); step(); step();
        check("s5 ack fresh",  lb4.ack,  1);
        check("s5 data fresh", lb4.data, 8'h3C);
        step();

        // Highest source, with req held while busy
        start4(2'd3, 8'hC3, 1'b1);
        step(); lb4.addr = 2'd1;
        check("s6 sel_en top", lb4.sel_en, 4'b1000);
        step(); step(); step();
        check("s6 ack",  lb4.ack,  1);
        check("s6 data", lb4.data, 8'hC3);
        step(); lb4.req = 1'b0;
        check("s6 busy c5", lb4.busy, 0);
        step();
        check("s6 busy c6", lb4.busy, 0);

        // Out-of-range address on the 3-source instance, then a legal read there
        lb3.req = 1'b1; lb3.addr = 2'd3; lb3.bus_in = 8'h99; lb3.bus_drv = 1'b1;
        step(); lb3.req = 1'b0;
        check("oob err",    lb3.err,    1);
        check("oob ack",    lb3.ack,    0);
        check("oob busy",   lb3.busy,   1);
        check("oob sel_en", lb3.sel_en, 0);
        step();
        check("oob idle",     lb3.busy,   0);
        check("oob sel_en2",  lb3.sel_en, 0);
        check("oob data",     lb3.data,   0);
        lb3.req = 1'b1; lb3.addr = 2'd2;
        step(); lb3.req = 1'b0;
        check("s3src sel_en", lb3.sel_en, 3'b100);
        step(); step(); step();
        check("s3src ack",  lb3.ack,  1);
        check("s3src data", lb3.data, 8'h99);
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
